// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the divider datapath and its
// inverse (quotient_remultiplier), plus the benches that drive them.
//   QW_DEF / DW_DEF : default quotient and divisor/remainder widths
//   state_t         : sequencing states of the shift-and-add remultiplier
package divider_pkg;

  localparam int QW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/quotient_remultiplier.sv
// quotient_remultiplier: rebuilds a dividend from a divider result,
// dvdnd_out = q * dvisor + r, using one shift-and-add step per quotient bit.
//
// state | meaning
// IDLE  | ready for a new {q, dvisor, r} triple
// RUN   | one multiplier bit per cycle, LSB first, QW cycles
// DONE  | result presented, held until out_ready
//
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : input handshake for q, dvisor, r
//   q [QW]                : quotient
//   dvisor [DW], r [DW]   : divisor and remainder
//   out_valid / out_ready : output handshake
//   dvdnd_out [QW+DW]     : reconstructed dividend
//   rem_err               : r >= dvisor (includes dvisor == 0), informational
module quotient_remultiplier
  import divider_pkg::*;
#(
  parameter int QW = QW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [QW-1:0]    q,
  input  logic [DW-1:0]    dvisor,
  input  logic [DW-1:0]    r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW+DW-1:0] dvdnd_out,
  output logic             rem_err
);

  localparam int RW = QW + DW;
  localparam int CW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  state_t        state;
  logic [QW-1:0] q_sh;
  logic [RW-1:0] d_sh;
  logic [RW-1:0] acc;
  logic [CW-1:0] cnt;

  // Max result is 2^RW - 2^QW, so the RW-bit accumulator never needs a carry-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      q_sh    <= '0;
      d_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      rem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            q_sh    <= q;
            d_sh    <= {{QW{1'b0}}, dvisor};
            acc     <= {{QW{1'b0}}, r};
            rem_err <= (r >= dvisor);
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (q_sh[0]) acc <= acc + d_sh;
          q_sh <= q_sh >> 1;
          d_sh <= d_sh << 1;
          cnt  <= cnt + CW'(1);
          // Fixed QW steps: no early exit on zero q_sh keeps latency constant.
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dvdnd_out = acc;

endmodule

// File: tb/tb_quotient_remultiplier.sv
module tb_quotient_remultiplier;
  import divider_pkg::*;

  localparam int QW = QW_DEF;
  localparam int DW = DW_DEF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [QW-1:0]    q = '0;
  logic [DW-1:0]    dvisor = '0;
  logic [DW-1:0]    r = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [QW+DW-1:0] dvdnd_out;
  logic             rem_err;

  quotient_remultiplier #(.QW(QW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .q(q), .dvisor(dvisor), .r(r),
    .out_valid(out_valid), .out_ready(out_ready),
    .dvdnd_out(dvdnd_out), .rem_err(rem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint dvdnd;
    bit     err;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   prev_accept = 0;
  bit   prev_ov = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT delivers a result.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) check("latency", cyc - accept_cyc, QW);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got dvdnd_out %0d, expected no output", dvdnd_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dvdnd_out", dvdnd_out, e.dvdnd);
          check("rem_err", rem_err, e.err);
        end
      end
    end
  end

  // Reference: reconstructed dividend is plain q*d + r; rem_err is r >= d.
  task automatic send_ref(input longint qv, input longint dv, input longint rv,
                          input longint exp_d, input bit exp_e);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0, expected 1 within 60 cycles");
      return;
    end
    q = QW'(qv);
    dvisor = DW'(dv);
    r = DW'(rv);
    in_valid = 1'b1;
    e.dvdnd = exp_d;
    e.err = exp_e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    prev_accept = accept_cyc;
    accept_cyc = cyc;
    in_valid = 1'b0;
    q = QW'($urandom);
    dvisor = DW'($urandom);
    r = DW'($urandom);
  endtask

  task automatic send(input longint qv, input longint dv, input longint rv);
    send_ref(qv, dv, rv, qv * dv + rv, rv >= dv);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int n;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dvdnd_out", dvdnd_out, 0);
    check("rst_rem_err", rem_err, 0);
    #10 rst_n = 1'b1;

    // Gradient sample, max operands, zero divisor.
    send(170, 150, 100);
    drain();
    check("grad_sample_ref", 170 * 150 + 100, 25600);
    send(255, 65535, 65534);
    drain();
    send(0, 0, 5);
    drain();

    // Backpressure: result held for 5 cycles with out_ready low.
    out_ready = 1'b0;
    send(3, 7, 2);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_data", dvdnd_out, 23);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_handshake", out_valid, 0);
    check("bp_in_ready_after", in_ready, 1);
    drain();

    // Reset mid-RUN discards the transaction.
    send(200, 300, 1);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_dvdnd_out", dvdnd_out, 0);
    sb.delete();
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    send(1, 1, 0);
    drain();

    // Back-to-back: divider model triples must rebuild the original dividend.
    for (int i = 0; i < 100; i++) begin
      longint gh, gv, dd, dv;
      gh = $urandom_range(255, 0);
      gv = $urandom_range(255, 1);
      dd = gh * 256;
      dv = gh + gv;
      send_ref(dd / dv, dv, dd % dv, dd, 1'b0);
      if (i > 0) check("accept_spacing", accept_cyc - prev_accept, QW + 2);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/quotient_remultiplier.md
# quotient_remultiplier

Sequential shift-and-add unit that rebuilds a dividend from a `divider` result: `dvdnd_out = q * dvisor + r`. It sits downstream of the combinational restoring divider in the gradient-ratio path (`dvdnd = gradh1*256`, `dvisor = gradh1+gradv1`). It serves as the inverse datapath for self-checking and for re-scaling quotients. It accepts one {q, dvisor, r} triple per transaction over a valid/ready handshake. It also flags remainders that violate `r < dvisor`.

## Interface
Parameters:
- `QW`, default 8: quotient width.
- `DW`, default 16: divisor and remainder width; result width is `QW+DW` (24).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: input triple valid.
- `in_ready`, out, 1: block can accept an input.
- `q`, in, QW: quotient.
- `dvisor`, in, DW: divisor.
- `r`, in, DW: remainder.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `dvdnd_out`, out, QW+DW: reconstructed dividend.
- `rem_err`, out, 1: `r >= dvisor`. Includes `dvisor == 0`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid && in_ready`, register `q` into a shift register and `dvisor` (zero-extended to QW+DW).
  - Load accumulator `acc <= r` (zero-extended).
  - Register `rem_err <= (r >= dvisor)`.
  - Clear `cnt <= 0`, go to RUN.
- RUN, one multiplier bit per cycle, LSB first:
  - If `q_sh[0]`, then `acc <= acc + d_sh`.
  - Always `q_sh >>= 1`, `d_sh <<= 1`, `cnt++`.
  - When `cnt == QW-1` on this edge, go to DONE.
  - There is no early exit on zero `q_sh`: latency is data-independent.
- DONE:
  - `out_valid = 1`; `dvdnd_out = acc`; `rem_err` is valid.
  - Both are held stable until `out_valid && out_ready`, then go to IDLE.
- Width rule: the maximum is (2^QW−1)(2^DW−1)+(2^DW−1) = 2^(QW+DW) − 2^QW < 2^(QW+DW). The QW+DW accumulator therefore never overflows; no carry-out is kept.
- `rem_err` is informational only. The result is computed regardless.
- `in_ready` is 0 in RUN and DONE. Inputs presented then are ignored, not queued.
- `in_valid` dropped while `in_ready = 1` has no effect.

## Timing
- Reset values (async assert, any state):
  - state = IDLE, `in_ready = 1`, `out_valid = 0`.
  - `dvdnd_out = 0`, `rem_err = 0`, `acc = 0`, `cnt = 0`.
- Reset mid-RUN or mid-DONE discards the transaction. No output pulse occurs.
- Reset release is used synchronously. The first accept is possible on the first rising edge with `rst_n` high.
- Latency: input accepted at edge N, then RUN edges N+1..N+QW, then `out_valid = 1` after edge N+QW (8 cycles for defaults).
- Throughput: with `out_ready` held high, the output handshake happens at edge N+QW+1 and the next accept at N+QW+2. That is one transaction per QW+2 cycles (10).
- No simultaneous accept-and-deliver: DONE→IDLE always takes one edge.
- Backpressure: `out_valid`, `dvdnd_out` and `rem_err` are unchanged while `out_ready = 0`, for any number of cycles.
- All outputs are registered or decoded from the state register. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `divider_pkg`:
  - `QW_DEF = 8`, `DW_DEF = 16`.
  - State enum {IDLE, RUN, DONE}.
  - Reused by the `divider` wrapper and benches.
- Single module. No sub-module: the adder and shifters are inline. A `$clog2(QW)`-bit counter drives the termination.

## Test plan
- Gradient sample, gradh1=100, gradv1=50: `q=170, dvisor=150, r=100` → `dvdnd_out = 25600`, `rem_err = 0`, `out_valid` asserted exactly 8 cycles after accept.
- Maximum operands: `q=255, dvisor=65535, r=65534` → `dvdnd_out = 16776959` (0xFFFEFF), `rem_err = 0`, no wrap.
- Zero divisor: `q=0, dvisor=0, r=5` → `dvdnd_out = 5`, `rem_err = 1`.
- Backpressure: `q=3, dvisor=7, r=2` with `out_ready = 0` for 5 cycles after `out_valid`:
  - `dvdnd_out = 23` held stable and `in_ready = 0` throughout.
  - The handshake completes on the cycle `out_ready` rises.
  - `in_ready = 1` on the following cycle.
- Reset mid-RUN: assert `rst_n = 0` four cycles after accept:
  - `out_valid = 0` and `dvdnd_out = 0` immediately (asynchronous).
  - After release, `in_ready = 1`.
  - A fresh `q=1, dvisor=1, r=0` → `dvdnd_out = 1`.
- Back-to-back: 100 random triples from the `divider` model (`dvdnd` = gradh1*256, `dvisor` = gradh1+gradv1):
  - Every `dvdnd_out` equals the original `dvdnd`.
  - Every `rem_err = 0` when `dvisor ≠ 0`.
  - Accepts are spaced exactly 10 cycles apart.
